// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type and default frame geometry.
package uart_pkg;

  localparam int UART_DEFAULT_OVERSAMPLE = 16;
  localparam int UART_DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP_1,
    TX_STOP_2
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: flags the last tick of each bit period; clear restarts the period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic tx_clk_en,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    bit_end    = tx_clk_en && (tick_cnt_q == LAST_TICK);
    tick_cnt_d = tick_cnt_q;
    if (tx_clk_en) begin
      tick_cnt_d = (clear || bit_end) ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises start/data/parity/stop onto tx.
// Define UART_TX_CTS_EN to add the active-low cts_n flow-control input.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef UART_TX_CTS_EN
  input  logic                  cts_n,
`endif
  input  logic                  tx_clk_en,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  double_stop_bit,
  input  logic                  tx_queue_empty,
  input  logic [DATA_WIDTH-1:0] tx_queue_data,
  output logic                  tx_queue_re,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  dbl_stop_q, dbl_stop_d;
  logic                  tx_q, tx_d;
  logic                  bit_end, cts_ok, last_stop, frame_start;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q, cts_sync_d;

  always_comb cts_sync_d = {cts_sync_q[0], cts_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cts_sync_q <= '1;
    else       cts_sync_q <= cts_sync_d;
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .tx_clk_en(tx_clk_en),
    .clear    (frame_start || (state_q == TX_IDLE)),
    .bit_end  (bit_end)
  );

  always_comb begin
    last_stop   = (state_q == TX_STOP_2) || ((state_q == TX_STOP_1) && !dbl_stop_q);
    frame_start = tx_clk_en && !tx_queue_empty && cts_ok
                  && ((state_q == TX_IDLE) || (last_stop && bit_end));
    tx_queue_re = frame_start && !reset;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    dbl_stop_d = dbl_stop_q;
    tx_d       = tx_q;
    if (frame_start) begin
      // parity accumulator is seeded with the odd/even select so it ends as ^data ^ parity_odd
      state_d    = TX_START;
      shift_d    = tx_queue_data;
      bit_cnt_d  = '0;
      par_d      = parity_odd;
      par_en_d   = parity_en;
      dbl_stop_d = double_stop_bit;
      tx_d       = 1'b0;
    end else if (bit_end) begin
      unique case (state_q)
        TX_START: begin
          state_d = TX_DATA;
          tx_d    = shift_q[0];
        end
        TX_DATA: begin
          par_d     = par_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? TX_PARITY : TX_STOP_1;
            tx_d    = par_en_q ? par_d : 1'b1;
          end else begin
            tx_d = shift_d[0];
          end
        end
        TX_PARITY: begin
          state_d = TX_STOP_1;
          tx_d    = 1'b1;
        end
        TX_STOP_1: begin
          state_d = dbl_stop_q ? TX_STOP_2 : TX_IDLE;
          tx_d    = 1'b1;
        end
        TX_STOP_2: begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      dbl_stop_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      dbl_stop_q <= dbl_stop_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a FIFO model feeds the DUT, a line monitor decodes frames tick by tick.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx_clk_en = 1'b0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          double_stop_bit = 1'b0;
  logic          tx_queue_empty = 1'b1;
  logic [DW-1:0] tx_queue_data = '0;
  logic          tx_queue_re, tx, tx_busy;
`ifdef UART_TX_CTS_EN
  logic          cts_n = 1'b0;
`endif

  typedef struct { logic [11:0] bits; int len; } exp_t;
  typedef struct { logic [11:0] bits; int len; bit dur_ok; int gap; } obs_t;

  exp_t          exp_q[$];
  obs_t          obs_q[$];
  logic [DW-1:0] fifo_q[$];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  bit pop_pending = 0;

  bit          mon_active = 0;
  int          mon_bit, mon_cnt, mon_len, mon_gap;
  int          idle_ticks = 0;
  logic [11:0] mon_bits;
  bit          mon_ok;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef UART_TX_CTS_EN
    .cts_n          (cts_n),
`endif
    .tx_clk_en      (tx_clk_en),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .double_stop_bit(double_stop_bit),
    .tx_queue_empty (tx_queue_empty),
    .tx_queue_data  (tx_queue_data),
    .tx_queue_re    (tx_queue_re),
    .tx             (tx),
    .tx_busy        (tx_busy)
  );

  function automatic exp_t make_frame(logic [7:0] d, logic pe, logic po, logic ds);
    exp_t e;
    int n = 0;
    e.bits = '0;
    e.bits[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin
      e.bits[n] = d[i]; n++;
    end
    if (pe) begin
      e.bits[n] = (^d) ^ po; n++;
    end
    e.bits[n] = 1'b1; n++;
    if (ds) begin
      e.bits[n] = 1'b1; n++;
    end
    e.len = n;
    return e;
  endfunction

  // FIFO model, tick generator and line monitor; edge at +0, sample at +1, drive at +2, strobe at +3.
  always begin
    @(posedge clk);
    #1;
    if (pop_pending) begin
      pops++;
      if (fifo_q.size() > 0) fifo_q.delete(0);
    end
    if (reset) begin
      mon_active = 0;
      idle_ticks = 0;
    end else if (tx_clk_en) begin
      if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1;
          mon_bits   = '0;
          mon_bit    = 0;
          mon_cnt    = 1;
          mon_ok     = 1;
          mon_gap    = idle_ticks;
          mon_len    = (exp_q.size() > obs_q.size()) ? exp_q[obs_q.size()].len : 10;
        end else begin
          idle_ticks++;
        end
      end else if (mon_cnt == OS) begin
        mon_bit++;
        mon_bits[mon_bit] = tx;
        mon_cnt = 1;
      end else begin
        if (tx !== mon_bits[mon_bit]) mon_ok = 0;
        mon_cnt++;
      end
      if (mon_active && mon_bit == mon_len - 1 && mon_cnt == OS) begin
        obs_q.push_back('{bits: mon_bits, len: mon_len, dur_ok: mon_ok, gap: mon_gap});
        mon_active = 0;
        idle_ticks = 0;
      end
    end
    #1;
    tx_clk_en      = ~tx_clk_en;
    tx_queue_empty = (fifo_q.size() == 0);
    tx_queue_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    #1;
    pop_pending = tx_queue_re;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(make_frame(d, parity_en, parity_odd, double_stop_bit));
  endtask

  task automatic wait_obs(input int n, output bit got);
    for (int i = 0; i < 3000 && obs_q.size() < n; i++) step(1);
    got = (obs_q.size() >= n);
  endtask

  task automatic test_reset;
    step(3);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++;
    if (tx_queue_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b want 0", tx_queue_re); end
    reset = 1'b0;
    step(4);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_basic;
    int   p0 = pops;
    bit   got;
    exp_t e;
    obs_t o;
    parity_en = 0; parity_odd = 0; double_stop_bit = 0;
    push_byte(8'h55);
    for (int i = 0; i < 20 && !pop_pending; i++) step(1);
    checks++;
    if (!pop_pending) begin errors++; $display("FAIL basic_pop: no pop strobe seen, want one"); end
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL basic_latency: tx=%b busy=%b one clk after pop, want tx=0 busy=1", tx, tx_busy);
    end
    wait_obs(1, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL basic_frame_timeout: got no frame want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.bits !== e.bits || o.len != e.len) begin
        errors++; $display("FAIL basic_frame: got %h/%0d want %h/%0d", o.bits, o.len, e.bits, e.len);
      end
      checks++;
      if (!o.dur_ok) begin errors++; $display("FAIL basic_bit_duration: got uneven bits want %0d ticks each", OS); end
    end
    step(8);
    checks++;
    if (pops - p0 != 1) begin errors++; $display("FAIL basic_pop_count: got %0d want 1", pops - p0); end
  endtask

  task automatic test_parity;
    bit   got;
    exp_t e;
    obs_t o;
    parity_en = 1; double_stop_bit = 0;
    for (int k = 0; k < 2; k++) begin
      parity_odd = (k == 1);
      push_byte(8'h07);
      wait_obs(1, got);
      checks++;
      if (!got) begin
        errors++; $display("FAIL parity_timeout odd=%0d: got no frame want 1", k);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o.bits !== e.bits || o.len != 11 || !o.dur_ok) begin
          errors++;
          $display("FAIL parity_frame odd=%0d: got %h/%0d dur_ok=%0d want %h/11", k, o.bits, o.len, o.dur_ok, e.bits);
        end
        checks++;
        if (o.bits[9] !== (k == 0)) begin
          errors++; $display("FAIL parity_bit odd=%0d: got %b want %b", k, o.bits[9], k == 0);
        end
      end
      step(8);
    end
  endtask

  task automatic test_double_stop;
    bit   got;
    exp_t e;
    obs_t o;
    parity_en = 1; parity_odd = 0; double_stop_bit = 1;
    push_byte(8'hA5);
    for (int i = 0; i < 200 && !mon_active; i++) step(1);
    step(40);
    double_stop_bit = 0; parity_odd = 1; parity_en = 0;
    wait_obs(1, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL dstop_timeout: got no frame want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.bits !== e.bits || o.len != 12 || !o.dur_ok) begin
        errors++; $display("FAIL dstop_frame: got %h/%0d dur_ok=%0d want %h/12", o.bits, o.len, o.dur_ok, e.bits);
      end
    end
    step(8);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL dstop_idle: tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_back_to_back;
    int   p0 = pops;
    int   idle_cycles = 0;
    bit   got;
    exp_t e;
    obs_t o;
    parity_en = 0; parity_odd = 0; double_stop_bit = 0;
    push_byte(8'h12);
    push_byte(8'h34);
    for (int i = 0; i < 20 && !tx_busy; i++) step(1);
    for (int i = 0; i < 1000 && obs_q.size() < 2; i++) begin
      if (tx_busy !== 1'b1) idle_cycles++;
      step(1);
    end
    checks++;
    if (obs_q.size() < 2) begin
      errors++; $display("FAIL b2b_timeout: got %0d frames want 2", obs_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o.bits !== e.bits || o.len != e.len || !o.dur_ok) begin
          errors++; $display("FAIL b2b_frame%0d: got %h/%0d dur_ok=%0d want %h/%0d", k, o.bits, o.len, o.dur_ok, e.bits, e.len);
        end
        if (k == 1) begin
          checks++;
          if (o.gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle ticks want 0", o.gap); end
        end
      end
    end
    checks++;
    if (idle_cycles != 0) begin errors++; $display("FAIL b2b_busy: got %0d non-busy cycles want 0", idle_cycles); end
    step(8);
    checks++;
    if (pops - p0 != 2) begin errors++; $display("FAIL b2b_pop_count: got %0d want 2", pops - p0); end
  endtask

  task automatic test_reset_mid_frame;
    int   p0 = pops;
    int   re_in_reset = 0;
    bit   got;
    exp_t e;
    obs_t o;
    parity_en = 0; parity_odd = 0; double_stop_bit = 0;
    push_byte(8'h3C);
    for (int i = 0; i < 400 && !(mon_active && mon_bit == 4); i++) step(1);
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_async: tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
    end
    void'(exp_q.pop_front());
    push_byte(8'hC3);
    for (int i = 0; i < 8; i++) begin
      step(1);
      #2;
      if (tx_queue_re !== 1'b0) re_in_reset++;
    end
    checks++;
    if (re_in_reset != 0) begin errors++; $display("FAIL midreset_pop: got %0d pop cycles in reset want 0", re_in_reset); end
    step(1);
    reset = 1'b0;
    wait_obs(1, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL midreset_timeout: got no frame want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.bits !== e.bits || o.len != e.len || !o.dur_ok) begin
        errors++; $display("FAIL midreset_frame: got %h/%0d dur_ok=%0d want %h/%0d", o.bits, o.len, o.dur_ok, e.bits, e.len);
      end
    end
    step(8);
    checks++;
    if (pops - p0 != 2) begin errors++; $display("FAIL midreset_pop_count: got %0d want 2", pops - p0); end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts;
    int   p0;
    int   n = 0;
    int   low_cycles = 0;
    bit   got;
    exp_t e;
    obs_t o;
    parity_en = 0; parity_odd = 0; double_stop_bit = 0;
    cts_n = 1'b1;
    step(4);
    p0 = pops;
    push_byte(8'h5A);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (tx !== 1'b1) low_cycles++;
    end
    checks++;
    if (pops != p0 || low_cycles != 0) begin
      errors++; $display("FAIL cts_hold: got pops=%0d low=%0d want 0/0", pops - p0, low_cycles);
    end
    cts_n = 1'b0;
    while (!pop_pending && n < 20) begin step(1); n++; end
    checks++;
    if (n < 2 || n > 5) begin errors++; $display("FAIL cts_release: got start after %0d clk want 2..5", n); end
    step(60);
    cts_n = 1'b1;
    push_byte(8'h96);
    wait_obs(1, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL cts_frame_timeout: got no frame want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.bits !== e.bits || !o.dur_ok) begin
        errors++; $display("FAIL cts_frame: got %h dur_ok=%0d want %h", o.bits, o.dur_ok, e.bits);
      end
    end
    step(300);
    checks++;
    if (pops - p0 != 1) begin errors++; $display("FAIL cts_next_held: got %0d pops want 1", pops - p0); end
    cts_n = 1'b0;
    wait_obs(1, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL cts_resume_timeout: got no frame want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.bits !== e.bits || !o.dur_ok) begin
        errors++; $display("FAIL cts_resume_frame: got %h dur_ok=%0d want %h", o.bits, o.dur_ok, e.bits);
      end
    end
    step(8);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_double_stop();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL stray_frames: got %0d unclaimed frames want 0", obs_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
